// File: rtl/mont_exp_ctrl_if.sv
// Command/response bundle between the exponentiation sequencer and mont_mul.
// The master side issues operand addresses; the slave side answers with a done pulse.
interface mont_exp_ctrl_if;
    logic        mm_start;
    logic [31:0] mm_A_addr;
    logic [31:0] mm_B_addr;
    logic [31:0] mm_N_addr;
    logic [31:0] mm_res_addr;
    logic        mm_done;

    modport master (
        output mm_start, mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr,
        input  mm_done
    );

    modport slave (
        input  mm_start, mm_A_addr, mm_B_addr, mm_N_addr, mm_res_addr,
        output mm_done
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving mont_mul in the Montgomery domain.
// Every mont_mul call is a two-cycle issue (A/B then N/res) followed by a wait for mm_done.
module mont_exp_ctrl #(
    parameter int EXP_BITS = 32,
    parameter int CNT_BITS = $clog2(2*EXP_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [EXP_BITS-1:0] exponent,
    input  logic [31:0]         base_addr,
    input  logic [31:0]         one_addr,
    input  logic [31:0]         N_addr,
    input  logic [31:0]         res_addr,
    mont_exp_ctrl_if.master     mm,
    output logic                busy,
    output logic                done,
    output logic [CNT_BITS:0]   mul_count
);

    localparam int BIT_W = $clog2(EXP_BITS+1);

    typedef enum logic [2:0] {
        IDLE, SCAN, ISSUE_AB, ISSUE_NR, WAIT, NEXT, FINISH
    } state_t;

    typedef enum logic [1:0] {
        OP_ONE, OP_INIT, OP_SQR, OP_MUL
    } op_t;

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [EXP_BITS-1:0] exp_q, exp_d;
    logic [BIT_W-1:0]    bits_q, bits_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         one_q, one_d;
    logic [31:0]         n_q, n_d;
    logic [31:0]         res_q, res_d;
    logic                mm_start_q, mm_start_d;
    logic [31:0]         a_out_q, a_out_d;
    logic [31:0]         b_out_q, b_out_d;
    logic [31:0]         n_out_q, n_out_d;
    logic [31:0]         res_out_q, res_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_BITS:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        exp_d   = exp_q;
        bits_d  = bits_q;
        base_d  = base_q;
        one_d   = one_q;
        n_d     = n_q;
        res_d   = res_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = exponent;
                    base_d  = base_addr;
                    one_d   = one_addr;
                    n_d     = N_addr;
                    res_d   = res_addr;
                    cnt_d   = '0;
                    bits_d  = BIT_W'(EXP_BITS);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (exp_q == '0) begin
                    op_d    = OP_ONE;
                    state_d = ISSUE_AB;
                end else begin
                    exp_d  = exp_q << 1;
                    bits_d = bits_q - BIT_W'(1);
                    if (exp_q[EXP_BITS-1]) begin
                        op_d    = OP_INIT;
                        state_d = ISSUE_AB;
                    end
                end
            end
            ISSUE_AB: state_d = ISSUE_NR;
            ISSUE_NR: state_d = WAIT;
            WAIT: begin
                if (mm.mm_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                // A square only consumes its bit here, so the multiply decision for that bit follows it.
                if (op_q == OP_ONE || (bits_q == '0 && op_q != OP_SQR)) begin
                    state_d = FINISH;
                end else if (op_q == OP_SQR) begin
                    exp_d  = exp_q << 1;
                    bits_d = bits_q - BIT_W'(1);
                    if (exp_q[EXP_BITS-1]) begin
                        op_d    = OP_MUL;
                        state_d = ISSUE_AB;
                    end else if (bits_q == BIT_W'(1)) begin
                        state_d = FINISH;
                    end else begin
                        op_d    = OP_SQR;
                        state_d = ISSUE_AB;
                    end
                end else begin
                    op_d    = OP_SQR;
                    state_d = ISSUE_AB;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mm_start_d = (state_d == ISSUE_AB) || (state_d == ISSUE_NR);
        a_out_d    = '0;
        b_out_d    = '0;
        n_out_d    = '0;
        res_out_d  = '0;
        if (state_d == ISSUE_AB) begin
            cnt_d = cnt_q + (CNT_BITS+1)'(1);
            case (op_d)
                OP_ONE:  begin a_out_d = one_d;  b_out_d = one_d;  end
                OP_INIT: begin a_out_d = base_d; b_out_d = one_d;  end
                OP_SQR:  begin a_out_d = res_d;  b_out_d = res_d;  end
                OP_MUL:  begin a_out_d = res_d;  b_out_d = base_d; end
                default: begin a_out_d = '0;     b_out_d = '0;     end
            endcase
        end
        if (state_d == ISSUE_NR) begin
            n_out_d   = n_d;
            res_out_d = res_d;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_ONE;
            exp_q      <= '0;
            bits_q     <= '0;
            base_q     <= '0;
            one_q      <= '0;
            n_q        <= '0;
            res_q      <= '0;
            mm_start_q <= 1'b0;
            a_out_q    <= '0;
            b_out_q    <= '0;
            n_out_q    <= '0;
            res_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            exp_q      <= exp_d;
            bits_q     <= bits_d;
            base_q     <= base_d;
            one_q      <= one_d;
            n_q        <= n_d;
            res_q      <= res_d;
            mm_start_q <= mm_start_d;
            a_out_q    <= a_out_d;
            b_out_q    <= b_out_d;
            n_out_q    <= n_out_d;
            res_out_q  <= res_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mm.mm_start    = mm_start_q;
    assign mm.mm_A_addr   = a_out_q;
    assign mm.mm_B_addr   = b_out_q;
    assign mm.mm_N_addr   = n_out_q;
    assign mm.mm_res_addr = res_out_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign mul_count      = cnt_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Randomized bench for mont_exp_ctrl: a behavioural mont_mul answers each issue and
// the expected op sequence, op count and modular result come from plain arithmetic.
module tb_mont_exp_ctrl;

    localparam int EXP_BITS = 32;
    localparam int CNT_W    = $clog2(2*EXP_BITS) + 1;
    localparam longint unsigned MOD_N = 241;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_pair_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       exponent = '0;
    logic [31:0]       base_addr = '0;
    logic [31:0]       one_addr = '0;
    logic [31:0]       n_addr = '0;
    logic [31:0]       res_addr = '0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  mul_count;
    logic              resp_done = 1'b0;
    logic              spur_done = 1'b0;

    mont_exp_ctrl_if mm_if();
    assign mm_if.mm_done = resp_done | spur_done;

    mont_exp_ctrl #(.EXP_BITS(EXP_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .exponent  (exponent),
        .base_addr (base_addr),
        .one_addr  (one_addr),
        .N_addr    (n_addr),
        .res_addr  (res_addr),
        .mm        (mm_if),
        .busy      (busy),
        .done      (done),
        .mul_count (mul_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    longint cyc = 0;
    int done_pulses = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_pulses <= done_pulses + 1;
    end

    longint unsigned mem [logic [31:0]];
    longint unsigned rm;
    longint unsigned rinv;
    logic [31:0] j_base, j_one, j_n, j_res;
    op_pair_t exp_ops [$];

    bit          r_second = 1'b0;
    bit          r_pending = 1'b0;
    int          r_count = 0;
    int          r_ops = 0;
    longint      r_first = -1;
    longint      r_last_done = -100;
    logic [31:0] r_a, r_b, r_n, r_res;

    task automatic checkOutput(input string tag, input longint unsigned got, input longint unsigned want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic longint unsigned rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    function automatic int bitlen(logic [31:0] e);
        for (int i = 31; i >= 0; i--) if (e[i]) return i + 1;
        return 0;
    endfunction

    function automatic longint unsigned powmod(longint unsigned b, logic [31:0] e);
        longint unsigned r = 1;
        longint unsigned x = b % MOD_N;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % MOD_N;
            x = (x * x) % MOD_N;
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Behavioural mont_mul: checks the two-cycle issue, then answers after a random delay.
    initial begin
        op_pair_t p;
        longint unsigned nv;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (r_second) begin
                checkOutput("nr_start", mm_if.mm_start, 1);
                checkOutput("nr_N", mm_if.mm_N_addr, j_n);
                checkOutput("nr_res", mm_if.mm_res_addr, j_res);
                checkOutput("nr_ab_zero", mm_if.mm_A_addr | mm_if.mm_B_addr, 0);
                r_n = mm_if.mm_N_addr;
                r_res = mm_if.mm_res_addr;
                r_second = 1'b0;
                r_pending = 1'b1;
                r_count = $urandom_range(0, 3);
            end else if (mm_if.mm_start) begin
                checkOutput("overlap", r_pending, 0);
                if (r_ops > 0) checkOutput("gap", (cyc - r_last_done >= 2), 1);
                if (r_first < 0) r_first = cyc;
                if (exp_ops.size() == 0) begin
                    checkOutput("extra_op", 1, 0);
                end else begin
                    p = exp_ops.pop_front();
                    checkOutput("op_A", mm_if.mm_A_addr, p.a);
                    checkOutput("op_B", mm_if.mm_B_addr, p.b);
                end
                checkOutput("ab_nr_zero", mm_if.mm_N_addr | mm_if.mm_res_addr, 0);
                r_a = mm_if.mm_A_addr;
                r_b = mm_if.mm_B_addr;
                r_ops++;
                r_second = 1'b1;
            end else begin
                checkOutput("idle_addr", mm_if.mm_A_addr | mm_if.mm_B_addr | mm_if.mm_N_addr | mm_if.mm_res_addr, 0);
                if (r_pending) begin
                    if (r_count == 0) begin
                        nv = rd(r_n);
                        mem[r_res] = (nv == 0) ? 64'd0 : (((rd(r_a) * rd(r_b)) % nv) * rinv) % nv;
                        resp_done = 1'b1;
                        r_pending = 1'b0;
                        r_last_done = cyc;
                    end else begin
                        r_count--;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] e, input bit spurious, input bit busy_start, input int abort_at);
        logic [31:0] r;
        longint unsigned b;
        int len, exp_cnt, scan_len, dpre;
        longint start_c;
        bit seen, aborted;

        r = $urandom & 32'hFFFF_FF00;
        j_base = r;
        j_one  = r + 32'h40;
        j_n    = r + 32'h80;
        j_res  = r + 32'hC0;
        b = $urandom_range(1, 240);
        mem[j_base] = (b * rm) % MOD_N;
        mem[j_one]  = rm;
        mem[j_n]    = MOD_N;
        mem[j_res]  = $urandom_range(0, 240);

        len = bitlen(e);
        exp_ops.delete();
        if (e == 0) begin
            exp_ops.push_back('{j_one, j_one});
            exp_cnt  = 1;
            scan_len = 1;
        end else begin
            exp_ops.push_back('{j_base, j_one});
            for (int i = len - 2; i >= 0; i--) begin
                exp_ops.push_back('{j_res, j_res});
                if (e[i]) exp_ops.push_back('{j_res, j_base});
            end
            exp_cnt  = len + $countones(e) - 1;
            scan_len = 33 - len;
        end
        r_ops = 0;
        r_first = -1;
        dpre = done_pulses;

        tick();
        start = 1'b1;
        exponent = e;
        base_addr = j_base;
        one_addr = j_one;
        n_addr = j_n;
        res_addr = j_res;
        start_c = cyc;
        tick();
        start = 1'b0;
        exponent = $urandom;
        base_addr = $urandom;
        one_addr = $urandom;
        n_addr = $urandom;
        res_addr = $urandom;
        checkOutput("busy_rise", busy, 1);
        if (spurious) spur_done = 1'b1;

        seen = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < 3000 && !seen && !aborted; i++) begin
            tick();
            spur_done = 1'b0;
            if (busy_start && i == 1) begin
                start = 1'b1;
                exponent = $urandom;
            end
            if (busy_start && i == 2) start = 1'b0;
            if (done) seen = 1'b1;
            if (abort_at > 0 && r_ops >= abort_at && r_pending && !mm_if.mm_start) aborted = 1'b1;
        end

        if (aborted) begin
            rst_n = 1'b0;
            tick();
            checkOutput("rst_mm_start", mm_if.mm_start, 0);
            checkOutput("rst_addr", mm_if.mm_A_addr | mm_if.mm_B_addr | mm_if.mm_N_addr | mm_if.mm_res_addr, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_count", mul_count, 0);
            r_pending = 1'b0;
            r_second = 1'b0;
            resp_done = 1'b0;
            exp_ops.delete();
            rst_n = 1'b1;
            repeat (10) tick();
            checkOutput("abort_no_done", done_pulses - dpre, 0);
            checkOutput("abort_idle", busy, 0);
        end else begin
            checkOutput("done_seen", seen, 1);
            checkOutput("busy_at_done", busy, 1);
            checkOutput("mul_count", mul_count, exp_cnt);
            checkOutput("ops_left", exp_ops.size(), 0);
            checkOutput("scan_len", r_first - start_c, scan_len + 1);
            checkOutput("result", rd(j_res), (powmod(b, e) * rm) % MOD_N);
            tick();
            checkOutput("busy_fall", busy, 0);
            checkOutput("done_fall", done, 0);
            tick();
            checkOutput("done_pulses", done_pulses - dpre, 1);
        end
    endtask

    initial begin
        rm = 1;
        for (int i = 0; i < 128; i++) rm = (rm * 2) % MOD_N;
        rinv = 0;
        for (longint unsigned x = 1; x < MOD_N; x++) if ((rm * x) % MOD_N == 1) rinv = x;

        rst_n = 1'b0;
        repeat (3) tick();
        checkOutput("reset_mm_start", mm_if.mm_start, 0);
        checkOutput("reset_addr", mm_if.mm_A_addr | mm_if.mm_B_addr | mm_if.mm_N_addr | mm_if.mm_res_addr, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_count", mul_count, 0);
        rst_n = 1'b1;
        tick();

        applyStimulus(32'd0, 1'b0, 1'b0, 0);
        applyStimulus(32'd1, 1'b1, 1'b0, 0);
        applyStimulus(32'd11, 1'b0, 1'b0, 0);
        applyStimulus(32'h8000_0000, 1'b0, 1'b0, 0);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b1, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b1, 0);
        end
        applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 3);
        applyStimulus(32'd3, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Sequencer that sits directly upstream of mont_mul and computes a modular exponentiation, res = base^exponent mod N, entirely in the Montgomery domain.
- Uses left-to-right square-and-multiply and issues one mont_mul operation per step through mont_mul's two-cycle start protocol.
- Never touches the LSU itself: all operands live in memory, and mont_mul performs the fetches and writebacks.
- Driven by the core's custom-instruction decode, which supplies the exponent and the operand addresses.

Parameters:
- EXP_BITS, 32, exponent width in bits.
- CNT_BITS, $clog2(2*EXP_BITS), width of the mul_count output.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request a new exponentiation; sampled in IDLE only.
- exponent, input, EXP_BITS, exponent; latched together with the addresses when start is accepted.
- base_addr, input, 32, address of base in Montgomery form.
- one_addr, input, 32, address of R mod N (Montgomery one).
- N_addr, input, 32, address of the modulus.
- res_addr, input, 32, address where the result is written; also used as the working accumulator.
- mm_start, output, 1, start strobe to mont_mul.
- mm_A_addr, output, 32, mont_mul operand A address.
- mm_B_addr, output, 32, mont_mul operand B address.
- mm_N_addr, output, 32, mont_mul modulus address.
- mm_res_addr, output, 32, mont_mul result address.
- mm_done, input, 1, one-cycle completion pulse from mont_mul.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle completion pulse.
- mul_count, output, CNT_BITS+1, number of mont_mul operations issued for the current or last job.

Behaviour:
- Reset (synchronous, rst_n low at a clk edge):
  - state goes to IDLE;
  - all outputs are 0: mm_start, all mm_* addresses, busy, done, mul_count;
  - latched registers are cleared.
- Reset mid-operation: abandon the job immediately, with no done pulse. mont_mul shares rst_n, so it is reset in the same cycle.
- States are IDLE, SCAN, ISSUE_AB, ISSUE_NR, WAIT, NEXT, FINISH.
- IDLE:
  - On start=1: latch exponent and the four addresses, clear mul_count, load bit counter = EXP_BITS, go to SCAN.
  - While busy, start is ignored.
- SCAN (one exponent bit per cycle):
  - If latched exponent == 0: op = ONE (A=one_addr, B=one_addr). This yields R mod N, the Montgomery one. Go to ISSUE_AB.
  - Else if exp MSB == 1: op = INIT (A=base_addr, B=one_addr), consume the bit (shift exp left, bit counter −1), go to ISSUE_AB.
  - Else: shift exp left, bit counter −1, stay in SCAN.
  - SCAN lasts (leading-zero count + 1) cycles.
- ISSUE_AB: mm_start=1, mm_A_addr and mm_B_addr driven per op; mul_count +1; go to ISSUE_NR.
- ISSUE_NR: mm_start=1, mm_N_addr=N_addr, mm_res_addr=res_addr; go to WAIT.
- In all other states, mm_start=0 and all mm_* addresses are 0.
- WAIT: hold until mm_done=1, then go to NEXT. mm_done in any other state is ignored.
- NEXT: exactly one idle cycle, guaranteeing mont_mul is back in IDLE before the next issue. Then:
  - If the last op was ONE, or the bit counter is 0 and the last op was not SQR: go to FINISH.
  - Else if the last op was SQR and the current exp MSB == 1: op = MUL (A=res_addr, B=base_addr), consume the bit, go to ISSUE_AB.
  - Else if the last op was SQR and the MSB == 0: consume the bit, then:
    - bit counter now 0: go to FINISH;
    - otherwise: op = SQR (A=res_addr, B=res_addr), go to ISSUE_AB.
  - Else (last op was INIT or MUL, bit counter > 0): op = SQR, go to ISSUE_AB. The bit is not consumed; the next NEXT tests it.
- FINISH: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- res_addr aliasing with A/B is legal, because mont_mul fetches all operands before writing.
- Operation count for exponent e != 0 with bit length L and popcount P: 1 + (L−1) + (P−1) = L + P − 1. For e = 0 the count is 1.
- Latency from start to done (excluding mont_mul time): 1 + SCAN + ops × 4 + 1 cycles.

Test Plan:
- exponent=0 → one op (A=one_addr, B=one_addr, N=N_addr, res=res_addr); mul_count=1; done pulses once; memory[res] = R mod N.
- exponent=1 → SCAN 32 cycles, one op INIT (A=base, B=one); mul_count=1.
- exponent=11 (0b1011), behavioural mont_mul model (WORDS=4, N=0xF1 padded, R=2^128) → op sequence INIT, SQR, SQR, MUL, SQR, MUL; mul_count=6; result is the Montgomery form of base^11 mod 0xF1.
- exponent=0x80000000 → SCAN 1 cycle, INIT + 31 SQR, mul_count=32; exponent=0xFFFFFFFF → mul_count=63.
- Handshake: every issue shows mm_start high exactly 2 consecutive cycles; A/B valid in the first, N/res in the second; ≥1 idle cycle after each mm_done; start pulsed during busy is ignored; a spurious mm_done during SCAN is ignored.
- rst_n low for 1 cycle during WAIT → next cycle state is IDLE, all outputs 0, no done; a fresh start with exponent=3 completes with mul_count=3.
